// File: rtl/radio_packer.sv
// Packs 1-bit I/Q sample streams into {q_word, i_word} words held in a small FIFO.
// Define RADIO_PACKER_OVF_COUNT_EN to add the saturating dropped-word counter port.
module radio_packer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk16,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       data_i,
    input  logic                       data_q,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [2*WIDTH-1:0]         m_tdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
`ifdef RADIO_PACKER_OVF_COUNT_EN
    ,
    output logic [15:0]                ovf_count
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [CW-1:0]        cnt;
    // Only WIDTH-1 samples are stored; the final sample joins the word on its push edge.
    logic [WIDTH-2:0]     shift_i;
    logic [WIDTH-2:0]     shift_q;
    logic [2*WIDTH-1:0]   mem [DEPTH];
    logic [LW-1:0]        wr_ptr;
    logic [LW-1:0]        rd_ptr;

    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 push_ok;
    logic                 drop;
    logic [2*WIDTH-1:0]   word;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == LEVEL_FULL);
    assign m_tvalid = (level != '0);
    assign m_tdata  = mem[rd_ptr[AW-1:0]];
    assign word     = {data_q, shift_q, data_i, shift_i};

    always_comb begin
        push    = en && (cnt == CNT_LAST);
        pop     = m_tvalid && m_tready;
        // A full FIFO still takes the word when the head leaves on the same edge.
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
    end

    always_ff @(posedge clk16) begin
        if (!rst_n) begin
            cnt      <= '0;
            shift_i  <= '0;
            shift_q  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (en) begin
                shift_i <= {data_i, shift_i[WIDTH-2:1]};
                shift_q <= {data_q, shift_q[WIDTH-2:1]};
                cnt     <= cnt + 1'b1;
            end else begin
                cnt     <= '0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= word;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef RADIO_PACKER_OVF_COUNT_EN
    always_ff @(posedge clk16) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (drop && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_radio_packer.sv
// Randomised and directed bench for radio_packer (WIDTH=8, DEPTH=4) against a
// queue-based word model; outputs are compared every cycle on the falling edge.
module tb_radio_packer;

    localparam int W = 8;
    localparam int D = 4;

    logic           clk16;
    logic           rst_n;
    logic           en;
    logic           data_i;
    logic           data_q;
    logic           m_tvalid;
    logic           m_tready;
    logic [2*W-1:0] m_tdata;
    logic [2:0]     level;
    logic           overflow;
`ifdef RADIO_PACKER_OVF_COUNT_EN
    logic [15:0]    ovf_count;
`endif

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    // ---------------- clock ----------------
    initial begin
        clk16 = 0;
        forever #5 clk16 = ~clk16;
    end

    radio_packer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk16    (clk16),
        .rst_n    (rst_n),
        .en       (en),
        .data_i   (data_i),
        .data_q   (data_q),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .level    (level),
        .overflow (overflow)
`ifdef RADIO_PACKER_OVF_COUNT_EN
        ,
        .ovf_count(ovf_count)
`endif
    );

    // ---------------- reference model ----------------
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   m_wi;
    logic [W-1:0]   m_wq;
    int             m_ns = 0;
    bit             m_ovf = 0;
    int             m_ovf_cnt = 0;

    always @(posedge clk16) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ns      = 0;
            m_wi      = '0;
            m_wq      = '0;
            m_ovf     = 0;
            m_ovf_cnt = 0;
        end else begin
            if (exp_q.size() > 0 && m_tready) void'(exp_q.pop_front());
            if (en) begin
                m_wi[m_ns] = data_i;
                m_wq[m_ns] = data_q;
                m_ns++;
                if (m_ns == W) begin
                    m_ns = 0;
                    if (exp_q.size() < D) begin
                        exp_q.push_back({m_wq, m_wi});
                    end else begin
                        m_ovf = 1;
                        if (m_ovf_cnt < 65535) m_ovf_cnt++;
                    end
                end
            end else begin
                m_ns = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk16) begin
        if (checking) begin
            chk("m_tvalid", 64'(m_tvalid), 64'(exp_q.size() > 0));
            chk("level", 64'(level), 64'(exp_q.size()));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (exp_q.size() > 0) chk("m_tdata", 64'(m_tdata), 64'(exp_q[0]));
`ifdef RADIO_PACKER_OVF_COUNT_EN
            chk("ovf_count", 64'(ovf_count), 64'(m_ovf_cnt));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic r, input logic e, input logic di, input logic dq, input logic rdy);
        rst_n    = r;
        en       = e;
        data_i   = di;
        data_q   = dq;
        m_tready = rdy;
        @(posedge clk16);
        #1;
    endtask

    task automatic run(input int n, input logic di, input logic dq, input logic rdy);
        for (int k = 0; k < n; k++) step(1, 1, di, dq, rdy);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 0; en = 0; data_i = 0; data_q = 0; m_tready = 1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        checking = 1;
        chk("reset_valid", 64'(m_tvalid), 64'd0);
        chk("reset_tdata", 64'(m_tdata), 64'd0);
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);

        // constant I=1, Q=0
        run(7, 1, 0, 1);
        chk("const_latency_valid7", 64'(m_tvalid), 64'd0);
        run(1, 1, 0, 1);
        chk("const_valid8", 64'(m_tvalid), 64'd1);
        chk("const_tdata", 64'(m_tdata), 64'h00FF);
        run(8, 1, 0, 1);
        chk("const_second_word", 64'(m_tdata), 64'h00FF);

        // alternating I = 1,0,1,0..., Q inverse
        for (int k = 0; k < W; k++) step(1, 1, logic'(k % 2 == 0), logic'(k % 2 != 0), 1);
        chk("alt_tdata", 64'(m_tdata), 64'hAA55);

        // overflow: five words with tready low, first word all ones
        step(1, 0, 0, 0, 1);
        run(8, 1, 1, 0);
        run(24, 0, 0, 0);
        chk("ovf_level4", 64'(level), 64'd4);
        chk("ovf_not_yet", 64'(overflow), 64'd0);
        run(8, 0, 1, 0);
        chk("ovf_level_held", 64'(level), 64'd4);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_head_word1", 64'(m_tdata), 64'hFFFF);
`ifdef RADIO_PACKER_OVF_COUNT_EN
        chk("ovf_count1", 64'(ovf_count), 64'd1);
`endif

        // full with a pop on the completing edge of word 5
        step(0, 0, 0, 0, 0);
        chk("rst_clears_ovf", 64'(overflow), 64'd0);
        run(8, 0, 0, 0);
        run(8, 1, 0, 0);
        run(16, 0, 0, 0);
        run(7, 0, 1, 0);
        run(1, 0, 1, 1);
        chk("concur_level", 64'(level), 64'd4);
        chk("concur_overflow", 64'(overflow), 64'd0);
        chk("concur_head_word2", 64'(m_tdata), 64'h00FF);

        // partial word discard
        step(0, 0, 0, 0, 1);
        run(3, 1, 1, 1);
        step(1, 0, 1, 1, 1);
        run(7, 0, 1, 1);
        chk("partial_valid7", 64'(m_tvalid), 64'd0);
        run(1, 0, 1, 1);
        chk("partial_valid8", 64'(m_tvalid), 64'd1);
        chk("partial_tdata", 64'(m_tdata), 64'hFF00);

        // reset mid-word with two words queued
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 19; k++) step(1, 1, 1'($urandom), 1'($urandom), 0);
        chk("midrst_level2", 64'(level), 64'd2);
        step(0, 1, 1, 1, 0);
        chk("midrst_valid", 64'(m_tvalid), 64'd0);
        chk("midrst_level", 64'(level), 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        run(7, 1, 0, 1);
        chk("midrst_valid7", 64'(m_tvalid), 64'd0);
        run(1, 1, 0, 1);
        chk("midrst_valid8", 64'(m_tvalid), 64'd1);
        chk("midrst_tdata", 64'(m_tdata), 64'h00FF);

        // randomised traffic
        for (int k = 0; k < 4000; k++) begin
            step(logic'($urandom_range(0, 599) != 0),
                 logic'($urandom_range(0, 15) != 0),
                 1'($urandom), 1'($urandom),
                 logic'($urandom_range(0, 3) == 0));
        end
        for (int k = 0; k < 2000; k++) begin
            step(1, logic'($urandom_range(0, 31) != 0), 1'($urandom), 1'($urandom),
                 logic'($urandom_range(0, 1)));
        end

        @(negedge clk16);
        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
